// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one iterative multiplier between two
// requesters, with post-reset flush, zero shortcut and watchdog.
module mult_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_err,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] product,
  input  logic        mult_end
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FLUSH, IDLE, START, WAIT, RESP
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [CW-1:0]  cnt;
  logic           rr;
  logic           owner;
  logic           gnt;
  logic           take;
  logic           zero;
  logic           cnt_last;
  logic           rsp_hs;
  logic [31:0]    sel_op1;
  logic [31:0]    sel_op2;

  // Contention goes to rr; a lone requester always wins.
  always_comb begin
    gnt      = (req0_valid && req1_valid) ? rr : req1_valid;
    take     = (state == IDLE) && (req0_valid || req1_valid);
    sel_op1  = gnt ? req1_op1 : req0_op1;
    sel_op2  = gnt ? req1_op2 : req0_op2;
    zero     = (sel_op1 == 32'd0) || (sel_op2 == 32'd0);
    cnt_last = (cnt == CW'(TIMEOUT - 1));
    rsp_hs   = owner ? rsp1_ready : rsp0_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FLUSH;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      FLUSH: if (cnt_last) nxt = IDLE;
      IDLE:  if (take) nxt = zero ? RESP : START;
      START: nxt = WAIT;
      WAIT:  if (mult_end || cnt_last) nxt = RESP;
      RESP:  if (rsp_hs) nxt = IDLE;
      default: nxt = FLUSH;
    endcase
  end

  always_comb begin
    req0_ready = take && !gnt;
    req1_ready = take && gnt;
    mult_begin = (state == START);
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) && owner;
  end

  // Operands stay latched on the multiplier inputs until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rr         <= 1'b0;
      owner      <= 1'b0;
      mult_op1   <= '0;
      mult_op2   <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        FLUSH: cnt <= cnt + CW'(1);
        IDLE: begin
          if (take) begin
            owner    <= gnt;
            mult_op1 <= sel_op1;
            mult_op2 <= sel_op2;
            cnt      <= '0;
            if (zero) begin
              rsp_result <= '0;
              rsp_err    <= 1'b0;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          if (mult_end) begin
            rsp_result <= product;
            rsp_err    <= 1'b0;
          end else if (cnt_last) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
        end
        RESP: if (rsp_hs) rr <= ~owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: randomized and directed traffic against a
// transaction-level model with a behavioural multiplier.
module tb_mult_arbiter;

  localparam int TO  = 40;
  localparam int LIM = 600;

  logic        clk;
  logic        rst;
  logic        v0, v1;
  logic        req0_ready, req1_ready;
  logic [31:0] a0, b0, a1, b1;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_rdy, rsp1_rdy;
  logic [63:0] rsp_result;
  logic        rsp_err;
  logic        mult_begin;
  logic [31:0] mult_op1, mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic        m_end;
  logic        stray;

  int total = 0;
  int bad   = 0;

  mult_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req1_valid(v1),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op1(a0), .req0_op2(b0),
    .req1_op1(a1), .req1_op2(b1),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_rdy), .rsp1_ready(rsp1_rdy),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .mult_begin(mult_begin),
    .mult_op1(mult_op1), .mult_op2(mult_op2),
    .product(product), .mult_end(mult_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mult_end = m_end | stray;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Unresettable multiplier model; op2 == 0 or hang never completes.
  bit hang = 0;
  int fixlat = 0;
  bit mbusy = 0;
  int left = 0;
  initial begin
    m_end = 1'b0;
    product = '0;
  end
  always @(posedge clk) begin
    m_end <= 1'b0;
    if (mult_begin && !hang && mult_op2 != 0) begin
      mbusy <= 1;
      left  <= (fixlat > 0) ? fixlat : $urandom_range(1, 30);
    end else if (mbusy) begin
      if (left <= 1) begin
        m_end   <= 1'b1;
        product <= longint'($signed(mult_op1)) * longint'($signed(mult_op2));
        mbusy   <= 0;
      end
      left <= left - 1;
    end
  end

  // Transaction-level reference model.
  int          since = 0;
  bit          busy_m = 0;
  bit          rr_m = 0;
  bit          m_id, m_zero, m_err;
  int          m_acc, m_avail;
  logic [63:0] m_res, m_exp;
  logic [31:0] m_a, m_b;
  logic [63:0] last_res0 = '0, last_res1 = '0;
  bit          last_err0 = 0, last_err1 = 0;
  int          begin_cnt = 0;
  int          acc_ids[$];

  always @(negedge clk) begin
    bit ok, g, e_r0, e_r1, e_v, e_beg;
    #2;
    if (rst) begin
      since  = 0;
      busy_m = 0;
      rr_m   = 0;
    end else begin
      ok   = (since >= TO) && !busy_m;
      g    = (v0 && v1) ? rr_m : v1;
      e_r0 = ok && v0 && !g;
      e_r1 = ok && v1 && g;
      check("ready0", {63'b0, req0_ready}, {63'b0, e_r0});
      check("ready1", {63'b0, req1_ready}, {63'b0, e_r1});
      e_beg = busy_m && !m_zero && (since == m_acc + 1);
      check("begin", {63'b0, mult_begin}, {63'b0, e_beg});
      e_v = busy_m && (m_avail >= 0) && (since >= m_avail);
      check("rsp0_valid", {63'b0, rsp0_valid}, {63'b0, e_v && !m_id});
      check("rsp1_valid", {63'b0, rsp1_valid}, {63'b0, e_v && m_id});
      if (e_v) begin
        check("result", rsp_result, m_res);
        check("err", {63'b0, rsp_err}, {63'b0, m_err});
      end
      if (busy_m && !m_zero && since > m_acc &&
          (m_avail < 0 || since < m_avail)) begin
        check("op1_hold", {32'b0, mult_op1}, {32'b0, m_a});
        check("op2_hold", {32'b0, mult_op2}, {32'b0, m_b});
      end
      if (mult_begin) begin_cnt++;
      if (busy_m && !m_zero && m_avail < 0 && since >= m_acc + 2) begin
        if (mult_end) begin
          m_avail = since + 1;
          m_res   = m_exp;
          m_err   = 0;
        end else if (since == m_acc + 1 + TO) begin
          m_avail = since + 1;
          m_res   = '0;
          m_err   = 1;
        end
      end
      if (e_v && (m_id ? rsp1_rdy : rsp0_rdy)) begin
        busy_m = 0;
        rr_m   = ~m_id;
        if (m_id) begin last_res1 = m_res; last_err1 = m_err; end
        else      begin last_res0 = m_res; last_err0 = m_err; end
      end
      if ((req0_ready && v0) || (req1_ready && v1)) begin
        busy_m = 1;
        m_id   = !(req0_ready && v0);
        m_a    = m_id ? a1 : a0;
        m_b    = m_id ? b1 : b0;
        m_acc  = since;
        m_zero = (m_a == 0) || (m_b == 0);
        m_exp  = longint'($signed(m_a)) * longint'($signed(m_b));
        acc_ids.push_back(int'(m_id));
        if (m_zero) begin
          m_avail = since + 1;
          m_res   = '0;
          m_err   = 0;
        end else begin
          m_avail = -1;
        end
      end
      since++;
    end
  end

  task automatic do_req(input bit id, input logic [31:0] a, b,
                        output int waited);
    if (id) begin v1 = 1; a1 = a; b1 = b; end
    else    begin v0 = 1; a0 = a; b0 = b; end
    waited = 0;
    forever begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
      waited++;
      if (waited > LIM) begin
        check("req_hs", {63'b0, id ? req1_ready : req0_ready}, 64'd1);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < LIM; i++) begin
      if (!busy_m) break;
      @(negedge clk);
    end
    check("idle_wait", {63'b0, busy_m}, 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'd0;
    if (r == 1) return 32'h8000_0000;
    return $urandom;
  endfunction

  task automatic rnd_stream(input bit id, input int n);
    int w;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(id, rnd_op(), rnd_op(), w);
      if (id) v1 = 0; else v0 = 0;
    end
  endtask

  bit rnd_on;

  initial begin
    int w, bc, st;
    rst = 1; v0 = 0; v1 = 0; stray = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    rsp0_rdy = 1; rsp1_rdy = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {62'b0, req0_ready, req1_ready}, 64'd0);
    check("rst_valid", {62'b0, rsp0_valid, rsp1_valid}, 64'd0);
    check("rst_begin", {62'b0, mult_begin, rsp_err}, 64'd0);
    check("rst_result", rsp_result, 64'd0);
    check("rst_ops", {mult_op1, mult_op2}, 64'd0);

    // Flush length and 3 x -5.
    @(negedge clk);
    rst = 0;
    do_req(0, 32'd3, -32'sd5, w);
    v0 = 0;
    check("flush_len", 64'(w), 64'(TO));
    wait_idle();
    check("m3x-5", last_res0, 64'hFFFF_FFFF_FFFF_FFF1);
    check("m3x-5_err", {63'b0, last_err0}, 64'd0);

    // Both requesters contend: grants must alternate.
    st = acc_ids.size();
    fork
      begin
        do_req(0, 32'd5, 32'd6, w);
        do_req(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, w);
        v0 = 0;
      end
      begin
        do_req(1, -32'sd7, 32'd3, w);
        do_req(1, 32'h8000_0000, 32'd2, w);
        v1 = 0;
      end
    join
    wait_idle();
    for (int i = st + 1; i < acc_ids.size(); i++)
      check("alternate", 64'(acc_ids[i]), 64'(1 - acc_ids[i-1]));
    check("max_sq", last_res0, 64'h3FFF_FFFF_0000_0001);
    check("min_x2", last_res1, 64'hFFFF_FFFF_0000_0000);

    // Zero shortcut never starts the multiplier.
    bc = begin_cnt;
    do_req(1, 32'd77, 32'd0, w);
    v1 = 0;
    wait_idle();
    do_req(1, 32'd0, 32'd77, w);
    v1 = 0;
    wait_idle();
    check("zero_nobegin", 64'(begin_cnt), 64'(bc));
    check("zero_res", last_res1, 64'd0);

    // Response back-pressure holds everything.
    rsp0_rdy = 0;
    do_req(0, 32'd9, 32'd11, w);
    v1 = 1; a1 = 32'd21; b1 = 32'd4;
    a0 = 32'd1; b0 = 32'd1;
    for (int i = 0; i < LIM && !rsp0_valid; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    #1;
    check("hold_r1", {63'b0, req1_ready}, 64'd0);
    @(negedge clk);
    rsp0_rdy = 1;
    do_req(1, 32'd21, 32'd4, w);
    v0 = 0; v1 = 0;
    check("rr_after_hold", 64'(w), 64'd1);
    wait_idle();
    check("hold_res0", last_res0, 64'd99);
    check("hold_res1", last_res1, 64'd84);

    // Watchdog, then a stray completion in IDLE.
    hang = 1;
    do_req(0, 32'd123, 32'd456, w);
    v0 = 0;
    wait_idle();
    hang = 0;
    check("wd_err", {63'b0, last_err0}, 64'd1);
    check("wd_res", last_res0, 64'd0);
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (3) @(negedge clk);
    do_req(1, -32'sd2, -32'sd3, w);
    v1 = 0;
    wait_idle();
    check("post_stray", last_res1, 64'd6);

    // Reset mid-operation.
    fixlat = 30;
    do_req(1, 32'd1000, 32'd2000, w);
    v1 = 0;
    v0 = 1; a0 = 32'd5; b0 = 32'd5;
    repeat (5) @(negedge clk);
    #3 rst = 1;
    #1;
    check("arst_ready", {62'b0, req0_ready, req1_ready}, 64'd0);
    check("arst_valid", {62'b0, rsp0_valid, rsp1_valid}, 64'd0);
    check("arst_begin", {62'b0, mult_begin, rsp_err}, 64'd0);
    check("arst_result", rsp_result, 64'd0);
    check("arst_ops", {mult_op1, mult_op2}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    fixlat = 0;
    do_req(0, 32'd3, 32'd7, w);
    v0 = 0;
    check("reflush_len", 64'(w), 64'(TO));
    wait_idle();
    check("post_rst", last_res0, 64'd21);

    // Randomized traffic with random response back-pressure.
    rnd_on = 1;
    fork
      begin
        fork
          rnd_stream(0, 15);
          rnd_stream(1, 15);
        join
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          @(negedge clk);
          rsp0_rdy = 1'($urandom);
          rsp1_rdy = 1'($urandom);
        end
      end
    join
    rsp0_rdy = 1; rsp1_rdy = 1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin controller that shares one iterative shift-add `multiply` unit between two requesters. It accepts signed 32×32 requests through valid/ready handshakes and latches the operands. It holds the operands stable on the multiplier inputs for the whole operation, pulses `mult_begin`, captures `product` on `mult_end` and returns the 64-bit result through a valid/ready response channel. It sits between two issuing units (e.g. ALU issue and a second pipe) and the single multiplier instance.

## Interface
- `TIMEOUT`, default 40: watchdog limit in cycles for one multiply, also the post-reset flush length; must exceed 35.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req0_valid`, `req1_valid` in 1: request present from requester 0/1.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when ANDed with valid.
- `req0_op1`, `req0_op2`, `req1_op1`, `req1_op2` in 32: signed operands.
- `rsp0_valid`, `rsp1_valid` out 1: result available for requester 0/1.
- `rsp0_ready`, `rsp1_ready` in 1: requester consumes result.
- `rsp_result` out 64: signed product, shared by both response channels.
- `rsp_err` out 1: watchdog expired; `rsp_result` is 0 when set.
- `mult_begin` out 1: one-cycle start pulse to multiplier.
- `mult_op1`, `mult_op2` out 32: operands to multiplier.
- `product` in 64: multiplier result.
- `mult_end` in 1: multiplier completion.

## Operation
- States: FLUSH, IDLE, START, WAIT, RESP.
- FLUSH, entered on reset: `mult_begin` is held low for TIMEOUT cycles so that any operation left running in the unresettable multiplier drains. `mult_end` is ignored. The state then goes to IDLE. No `req*_ready` is asserted.
- IDLE: grant is combinational from the valids and the round-robin pointer `rr`. If only one requester is valid, it is granted. If both are valid, requester `rr` is granted.
  - Only the granted requester sees `ready` = 1.
  - On handshake: latch op1/op2 and owner id, then clear the watchdog counter.
  - If either operand is 0: `rsp_result` ← 0, `rsp_err` ← 0, next state RESP. This shortcut is mandatory because the multiplier never asserts `mult_end` when op2 = 0.
  - Otherwise the next state is START.
- START: `mult_begin` = 1 for exactly one cycle, then WAIT.
- WAIT: `mult_op1`/`mult_op2` remain equal to the latched values. The multiplier samples operand signs throughout the operation, so they must not change.
  - On `mult_end` = 1: `rsp_result` ← `product`, `rsp_err` ← 0, then RESP.
  - If the counter reaches TIMEOUT first: `rsp_result` ← 0, `rsp_err` ← 1, then RESP.
- RESP: `rspN_valid` = 1 for the owner only. It is held, together with `rsp_result`/`rsp_err`, until `rspN_ready`. On that handshake `rr` ← ~owner and the state goes to IDLE.
- `mult_end` outside WAIT is ignored.
- At most one request is in flight. Neither requester is accepted while state ≠ IDLE.
- Arithmetic is two's-complement signed. Result bits are passed through unmodified from `product`.

## Timing
- Reset values: state FLUSH, `rr` = 0, all `req*_ready` / `rsp*_valid` / `mult_begin` / `rsp_err` = 0, `rsp_result` = 0, `mult_op1` / `mult_op2` = 0.
- Reset asserted mid-operation returns the block to FLUSH immediately. Any pending response is discarded.
- Accept at edge t, with nonzero operands: `mult_begin` is high in cycle t+1, and WAIT starts at t+2.
- The response is valid in the cycle after `mult_end`, i.e. RESP is entered at the edge that samples `mult_end`.
- Zero shortcut: accept at edge t, `rsp_valid` = 1 in cycle t+1.
- Minimum spacing between accepts is 2 cycles (shortcut, `rsp_ready` held high).
- The watchdog counts only in WAIT. It expires after TIMEOUT WAIT cycles.
- FLUSH lasts exactly TIMEOUT cycles after reset release. The first `ready` appears in cycle TIMEOUT.

## Test plan
- Reset, then `req0` 3 × −5 with a model multiplier: no ready for 40 cycles; then `mult_begin` is a single one-cycle pulse, `mult_op1`/`mult_op2` are stable through WAIT, `rsp0_valid` carries 0xFFFFFFFFFFFFFFF1 and `rsp_err` = 0.
- Both requesters valid continuously with `rsp_ready` = 1: grants alternate 0, 1, 0, 1. Each result goes to the correct channel, e.g. 0x7FFFFFFF × 0x7FFFFFFF → 0x3FFFFFFF00000001 and 0x80000000 × 2 → 0xFFFFFFFF00000000.
- `req1` with op2 = 0, and separately op1 = 0: `mult_begin` is never asserted, and `rsp1_valid` rises 1 cycle after accept with result 0.
- `rsp0_ready` held low for 10 cycles while `req1` is valid: `rsp0_valid`/`rsp_result` stay stable and `req1_ready` stays 0. After consume, `req1` is granted next.
- Model multiplier never raises `mult_end`: RESP after 40 WAIT cycles with `rsp_err` = 1 and result 0. A stray `mult_end` in IDLE is ignored.
- `rst` pulsed during WAIT: all outputs go to reset values asynchronously, FLUSH reruns, and no response is emitted for the aborted request.
